// File: rtl/data_mem_pkg.sv
// Shared definitions for the sized data memory.
//   SZ_*          : req_size encodings (byte, halfword, full word, reserved)
//   state_t       : controller states (CLEAR = zeroing pass, RUN = serving requests)
//   access_bytes(): number of bytes N touched by an access of a given size
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // The reserved size reports 1 byte so alignment math never divides by zero;
  // it is flagged as an error separately.
  function automatic int access_bytes(input logic [1:0] size, input int data_width);
    case (size)
      SZ_BYTE: return 1;
      SZ_HALF: return 2;
      SZ_WORD: return data_width / 8;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_align_extend.sv
// Combinational access shaper for one memory word.
//   size, sign_ext : access size code and load extension mode
//   offset         : byte offset of the access inside its word
//   rd_word        : whole word read from the array, big-endian (byte 0 = MS lane)
//   wdata          : store data, low N*8 bits used
//   err            : reserved size or misaligned offset
//   be             : per-byte write enable, bit i = byte offset i of the word
//   wr_word        : store data placed in its big-endian lanes
//   rd_data        : load result, sign/zero extended; 0 on error
module data_mem_align_extend
  import data_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  localparam int BYTES = DATA_WIDTH / 8,
  localparam int OFF_W = $clog2(BYTES)
) (
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [OFF_W-1:0]      offset,
  input  logic [DATA_WIDTH-1:0] rd_word,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  err,
  output logic [BYTES-1:0]      be,
  output logic [DATA_WIDTH-1:0] wr_word,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int IDX_W = $clog2(DATA_WIDTH);

  int                    n_bytes;
  int                    off;
  int                    shamt;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] unit;
  logic [IDX_W-1:0]      msb;
  logic                  ext;

  // NOTE: every output of this block gets a value on every path; a missed
  // assignment in always_comb would infer a latch.
  always_comb begin
    n_bytes = access_bytes(size, DATA_WIDTH);
    off     = int'(offset);
    err     = (size == SZ_RSVD) || ((off % n_bytes) != 0);
    // The LS byte of the unit sits at offset off+N-1, i.e. lane BYTES-off-N
    // counted from the bottom of the word.
    shamt   = err ? 0 : (BYTES - off - n_bytes) * 8;
    mask    = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - n_bytes * 8);
    unit    = (rd_word >> shamt) & mask;
    wr_word = (wdata & mask) << shamt;
    for (int i = 0; i < BYTES; i++) begin
      be[i] = !err && (i >= off) && (i < off + n_bytes);
    end
    msb     = IDX_W'(n_bytes * 8 - 1);
    ext     = sign_ext && (size != SZ_WORD) && unit[msb];
    rd_data = ext ? (unit | ~mask) : unit;
    if (err) begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressable big-endian data memory with byte/halfword/word accesses.
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : request handshake; ready only outside the clear pass
//   req_we/size/signed: store flag, access size, load extension mode
//   req_addr/wdata    : byte address, store data (low N*8 bits)
//   rsp_valid         : one-cycle strobe RD_LATENCY cycles after each accept
//   rsp_rdata/rsp_err : extended load data (0 for stores/errors), error flag
//   busy              : clear pass in progress
module data_memory_sized
  import data_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int RD_LATENCY     = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int UNIT_W = ADDR_WIDTH - OFF_W;

  state_t                state, state_nxt;
  logic [UNIT_W-1:0]     clr_cnt;
  logic                  accept;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  acc_err;
  logic [BYTES-1:0]      wr_be;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_data;

  logic [7:0] mem [DEPTH];

  logic [RD_LATENCY-1:0]                 v_pipe;
  logic [RD_LATENCY-1:0]                 e_pipe;
  logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] d_pipe;

  // ---------------- FSM ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RESET ? CLEAR : RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (&clr_cnt) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    busy      = (state == CLEAR);
    req_ready = (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

  assign accept = req_valid && req_ready;

  // ---------------- Array ----------------
  // The whole word containing req_addr is read; the shaper picks the lanes.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < BYTES; i++) begin
      rd_word[(BYTES-1-i)*8 +: 8] = mem[{req_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(i)}];
    end
  end

  data_mem_align_extend #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .size    (req_size),
    .sign_ext(req_signed),
    .offset  (req_addr[OFF_W-1:0]),
    .rd_word (rd_word),
    .wdata   (req_wdata),
    .err     (acc_err),
    .be      (wr_be),
    .wr_word (wr_word),
    .rd_data (rd_data)
  );

  // NOTE: the array has no reset branch; contents survive rst and are zeroed
  // only by the clear pass, which keeps it mappable to block RAM.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      for (int i = 0; i < BYTES; i++) begin
        mem[{clr_cnt, OFF_W'(i)}] <= 8'h00;
      end
    end else if (accept && req_we && !acc_err && !rst) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wr_be[i]) begin
          mem[{req_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(i)}] <= wr_word[(BYTES-1-i)*8 +: 8];
        end
      end
    end
  end

  // ---------------- Response pipeline ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      v_pipe <= '0;
      e_pipe <= '0;
      d_pipe <= '0;
    end else begin
      for (int k = RD_LATENCY - 1; k > 0; k--) begin
        v_pipe[k] <= v_pipe[k-1];
        e_pipe[k] <= e_pipe[k-1];
        d_pipe[k] <= d_pipe[k-1];
      end
      v_pipe[0] <= accept;
      e_pipe[0] <= accept && acc_err;
      d_pipe[0] <= (accept && !req_we) ? rd_data : '0;
    end
  end

  // Masking with rst drops a response that would otherwise surface in the
  // same cycle the reset is being applied (the RD_LATENCY=1 case).
  assign rsp_valid = v_pipe[RD_LATENCY-1] && !rst;
  assign rsp_err   = e_pipe[RD_LATENCY-1] && !rst;
  assign rsp_rdata = rst ? '0 : d_pipe[RD_LATENCY-1];

endmodule

// File: tb/tb_data_memory_sized.sv
module tb_data_memory_sized;

  localparam int DW = 16;
  localparam int AW = 8;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic          req_signed = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;

  logic          ready1, rsp_valid1, rsp_err1, busy1;
  logic [DW-1:0] rsp_rdata1;
  logic          ready2, rsp_valid2, rsp_err2, busy2;
  logic [DW-1:0] rsp_rdata2;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q1[$];
  exp_t q2[$];
  logic [7:0] model [256];

  data_memory_sized #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .CLEAR_ON_RESET(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid1),
    .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1), .busy(busy1)
  );

  data_memory_sized #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2), .CLEAR_ON_RESET(1'b1)
  ) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready2),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid2),
    .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2), .busy(busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Compares one instance's response port against the head of its queue.
  task automatic mon(input string tag, input logic v, input logic [DW-1:0] rd,
                     input logic e, input bit have, input exp_t f, output bit pop);
    pop = 1'b0;
    if (v) begin
      if (!have) begin
        check({tag, "_spurious_rsp"}, 32'd1, 32'd0);
      end else begin
        check({tag, "_rdata"}, 32'(rd), 32'(f.rdata));
        check({tag, "_err"}, 32'(e), 32'(f.err));
        check({tag, "_latency"}, 32'(cyc), 32'(f.due));
        pop = 1'b1;
      end
    end else if (have && f.due <= cyc) begin
      check({tag, "_missing_rsp"}, 32'd0, 32'd1);
      pop = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    bit   p1;
    exp_t f1;
    f1 = '{rdata: '0, err: 1'b0, due: 0};
    if (q1.size() > 0) f1 = q1[0];
    mon("lat1", rsp_valid1, rsp_rdata1, rsp_err1, q1.size() > 0, f1, p1);
    if (p1) void'(q1.pop_front());
  end

  always @(negedge clk) begin
    bit   p2;
    exp_t f2;
    f2 = '{rdata: '0, err: 1'b0, due: 0};
    if (q2.size() > 0) f2 = q2[0];
    mon("lat2", rsp_valid2, rsp_rdata2, rsp_err2, q2.size() > 0, f2, p2);
    if (p2) void'(q2.pop_front());
  end

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd3) ? 1 : 2;
  endfunction

  // Independent reference: byte-wise big-endian read of the model array.
  task automatic model_exp(input logic we, input logic [1:0] sz, input logic sg,
                           input logic [AW-1:0] a, output logic [DW-1:0] rd,
                           output logic er);
    int n;
    n  = nbytes(sz);
    er = (sz == 2'd3) || ((int'(a) % n) != 0);
    rd = '0;
    if (!er && !we) begin
      for (int i = 0; i < n; i++) rd = {rd[7:0], model[int'(a) + i]};
      if (n == 1 && sg) rd[15:8] = {8{rd[7]}};
    end
  endtask

  // Drives one request for one cycle; expected responses go to both queues.
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW-1:0] erd, input logic eer);
    int n;
    check("req_ready", 32'(ready1 & ready2), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz;
    req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    q1.push_back('{rdata: erd, err: eer, due: cyc});
    q2.push_back('{rdata: erd, err: eer, due: cyc + 1});
    req_valid = 1'b0;
    n = nbytes(sz);
    if (we && !eer) begin
      for (int i = 0; i < n; i++) model[int'(a) + i] = wd[(n-1-i)*8 +: 8];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q1.delete();
    q2.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
  endtask

  task automatic wait_clear();
    int n;
    n = 0;
    while ((busy1 || busy2) && n < 1000) begin
      if (ready1 || ready2) check("ready_during_clear", 32'd1, 32'd0);
      @(posedge clk); #1;
      n++;
    end
    check("clear_cycles", 32'(n), 32'd128);
    check("ready_after_clear", 32'({ready1, ready2}), 32'h3);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [DW-1:0] erd;
    logic          eer;
    logic          we, sg;
    logic [1:0]    sz;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;

    idle(2);
    // 1: reset state, clear pass length, fresh array reads zero
    do_reset();
    check("rst_busy", 32'({busy1, busy2}), 32'h3);
    check("rst_ready", 32'({ready1, ready2}), 32'h0);
    check("rst_rsp_valid", 32'({rsp_valid1, rsp_valid2}), 32'h0);
    check("rst_rsp_err", 32'({rsp_err1, rsp_err2}), 32'h0);
    check("rst_rsp_rdata", {rsp_rdata1, rsp_rdata2}, 32'h0);
    wait_clear();
    issue(0, 2'd2, 0, 8'h40, 16'h0, 16'h0000, 0);

    // 2: word store, byte/word loads with both extensions
    issue(1, 2'd2, 0, 8'h10, 16'hA1B2, 16'h0000, 0);
    issue(0, 2'd0, 0, 8'h10, 16'h0, 16'h00A1, 0);
    issue(0, 2'd0, 1, 8'h11, 16'h0, 16'hFFB2, 0);
    issue(0, 2'd2, 0, 8'h10, 16'h0, 16'hA1B2, 0);

    // 3: byte store lands in the LS lane of the big-endian word
    issue(1, 2'd0, 0, 8'h21, 16'h007F, 16'h0000, 0);
    issue(0, 2'd2, 0, 8'h20, 16'h0, 16'h007F, 0);
    issue(0, 2'd1, 1, 8'h20, 16'h0, 16'h007F, 0);

    // 4: misalignment and reserved size
    issue(0, 2'd2, 0, 8'h11, 16'h0, 16'h0000, 1);
    issue(1, 2'd2, 0, 8'h13, 16'hFFFF, 16'h0000, 1);
    issue(0, 2'd2, 0, 8'h12, 16'h0, 16'h0000, 0);
    issue(0, 2'd3, 0, 8'h10, 16'h0, 16'h0000, 1);
    issue(1, 2'd1, 0, 8'h21, 16'hBEEF, 16'h0000, 1);

    // 5: read-after-write back to back, both latencies
    issue(1, 2'd2, 0, 8'h30, 16'h1234, 16'h0000, 0);
    issue(0, 2'd2, 0, 8'h30, 16'h0, 16'h1234, 0);
    idle(3);

    // random traffic in 0x40..0x7F against the byte model
    for (int k = 0; k < 60; k++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(8'h40, 8'h7F));
      wd = DW'($urandom);
      model_exp(we, sz, sg, a, erd, eer);
      issue(we, sz, sg, a, wd, erd, eer);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(3);

    // 6: rst right after an accepted load drops its response and re-clears
    issue(0, 2'd2, 0, 8'h30, 16'h0, 16'h1234, 0);
    do_reset();
    wait_clear();
    issue(0, 2'd2, 0, 8'h30, 16'h0, 16'h0000, 0);
    issue(0, 2'd2, 0, 8'h10, 16'h0, 16'h0000, 0);
    idle(4);

    check("queue1_drained", 32'(q1.size()), 32'd0);
    check("queue2_drained", 32'(q2.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
